// File: rtl/timer_arbiter.sv
// Two-requester round-robin arbiter owning a shared 16-bit seconds timer.
// Sequences start/run/finish/release of the counter for the granted requester.
module timer_arbiter (
    input  logic        MCLK,
    input  logic        nRESET,
    input  logic        REQ0,
    input  logic        REQ1,
    input  logic [15:0] DUR0,
    input  logic [15:0] DUR1,
    output logic        GNT0,
    output logic        GNT1,
    output logic        DONE0,
    output logic        DONE1,
    output logic        ERR,
    output logic        BUSY,
    output logic        TMR_nSTART,
    output logic        TMR_nRESET,
    input  logic [15:0] TMR_TIME,
    input  logic        TMR_OVFL
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_FINISH,
        ST_RELEASE
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [15:0] dur_q, dur_d;

    logic        req_own;
    logic        winner;
    logic        run_live;
    logic        gnt0_d, gnt1_d, done0_d, done1_d, err_d, busy_d, nstart_d, nreset_d;

    assign req_own = owner_q ? REQ1 : REQ0;
    // On a tie the requester not served last wins; otherwise the lone requester.
    assign winner  = (REQ0 && REQ1) ? ~last_q : REQ1;

    // State register; all outputs are registered from their next-cycle values.
    always_ff @(posedge MCLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values; reset is synchronous, sampled on this edge only.
        if (!nRESET) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            dur_q      <= 16'd0;
            GNT0       <= 1'b0;
            GNT1       <= 1'b0;
            DONE0      <= 1'b0;
            DONE1      <= 1'b0;
            ERR        <= 1'b0;
            BUSY       <= 1'b0;
            TMR_nSTART <= 1'b1;
            TMR_nRESET <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            dur_q      <= dur_d;
            GNT0       <= gnt0_d;
            GNT1       <= gnt1_d;
            DONE0      <= done0_d;
            DONE1      <= done1_d;
            ERR        <= err_d;
            BUSY       <= busy_d;
            TMR_nSTART <= nstart_d;
            TMR_nRESET <= nreset_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        dur_d   = dur_q;
        unique case (state_q)
            ST_IDLE: begin
                if (REQ0 || REQ1) begin
                    owner_d = winner;
                    dur_d   = winner ? DUR1 : DUR0;
                    state_d = ST_START;
                end
            end
            ST_START:   state_d = ST_RUN;
            ST_RUN: begin
                if (!req_own || TMR_OVFL || (TMR_TIME >= dur_q))
                    state_d = ST_FINISH;
            end
            ST_FINISH: begin
                last_d  = owner_q;
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!req_own)
                    state_d = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output logic: values the outputs take after the coming edge.
    always_comb begin
        run_live = (state_q == ST_RUN) && req_own;
        err_d    = run_live && TMR_OVFL;
        done0_d  = run_live && (TMR_OVFL || (TMR_TIME >= dur_q)) && !owner_q;
        done1_d  = run_live && (TMR_OVFL || (TMR_TIME >= dur_q)) && owner_q;
        gnt0_d   = (state_d != ST_IDLE) && !owner_d;
        gnt1_d   = (state_d != ST_IDLE) && owner_d;
        busy_d   = (state_d != ST_IDLE);
        nstart_d = (state_d != ST_START);
        nreset_d = (state_d == ST_START) || (state_d == ST_RUN);
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter: each step pushes the hand-computed output
// vector for that cycle; an independent monitor pops and compares every cycle.
module tb_timer_arbiter;

    logic        MCLK = 1'b0;
    logic        nRESET, REQ0, REQ1, TMR_OVFL;
    logic [15:0] DUR0, DUR1, TMR_TIME;
    logic        GNT0, GNT1, DONE0, DONE1, ERR, BUSY, TMR_nSTART, TMR_nRESET;

    // Vector bit order: {GNT0,GNT1,DONE0,DONE1,ERR,BUSY,TMR_nSTART,TMR_nRESET}
    localparam logic [7:0] IDLE  = 8'h02;
    localparam logic [7:0] STA0  = 8'h85, STA1 = 8'h45;
    localparam logic [7:0] RUN0  = 8'h87, RUN1 = 8'h47;
    localparam logic [7:0] DN0   = 8'hA6, DN1  = 8'h56;
    localparam logic [7:0] ERR0  = 8'hAE;
    localparam logic [7:0] HOLD0 = 8'h86, HOLD1 = 8'h46;

    typedef struct {
        string      name;
        logic [7:0] v;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_mis = 0;

    timer_arbiter dut (
        .MCLK(MCLK), .nRESET(nRESET), .REQ0(REQ0), .REQ1(REQ1),
        .DUR0(DUR0), .DUR1(DUR1), .GNT0(GNT0), .GNT1(GNT1),
        .DONE0(DONE0), .DONE1(DONE1), .ERR(ERR), .BUSY(BUSY),
        .TMR_nSTART(TMR_nSTART), .TMR_nRESET(TMR_nRESET),
        .TMR_TIME(TMR_TIME), .TMR_OVFL(TMR_OVFL)
    );

    always #5 MCLK = ~MCLK;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare on the falling edge.
    always @(negedge MCLK) begin
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(e.name, {GNT0, GNT1, DONE0, DONE1, ERR, BUSY, TMR_nSTART, TMR_nRESET}, e.v);
        end
    end

    // Apply inputs for one edge, then queue the outputs expected after it.
    task automatic step(input string name, input logic nrst, input logic r0, input logic r1,
                        input logic [15:0] d0, input logic [15:0] d1,
                        input logic [15:0] t, input logic ov, input logic [7:0] v);
        exp_t x;
        nRESET = nrst; REQ0 = r0; REQ1 = r1;
        DUR0 = d0; DUR1 = d1; TMR_TIME = t; TMR_OVFL = ov;
        @(posedge MCLK);
        #2;
        x.name = name;
        x.v    = v;
        exp_q.push_back(x);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Single request, DUR0=3
        step("rst0",      0, 0, 0, 16'd0, 16'd0, 16'd0, 0, IDLE);
        step("rst1",      0, 1, 1, 16'd0, 16'd0, 16'd0, 1, IDLE);
        step("s_grant",   1, 1, 0, 16'd3, 16'd0, 16'd0, 0, STA0);
        step("s_run",     1, 1, 0, 16'd3, 16'd0, 16'd0, 0, RUN0);
        step("s_t0",      1, 1, 0, 16'd3, 16'd0, 16'd0, 0, RUN0);
        step("s_t1",      1, 1, 0, 16'd3, 16'd0, 16'd1, 0, RUN0);
        step("s_t2",      1, 1, 0, 16'd3, 16'd0, 16'd2, 0, RUN0);
        step("s_done",    1, 1, 0, 16'd3, 16'd0, 16'd3, 0, DN0);
        step("s_rel",     1, 1, 0, 16'd3, 16'd0, 16'd3, 0, HOLD0);
        step("s_relhold", 1, 1, 0, 16'd3, 16'd0, 16'd0, 0, HOLD0);
        step("s_idle",    1, 0, 0, 16'd3, 16'd0, 16'd0, 0, IDLE);
        step("s_idle2",   1, 0, 0, 16'd3, 16'd0, 16'd0, 0, IDLE);

        // Contention after reset: requester 0 first, then 1 after one IDLE cycle
        step("c_rst",     0, 0, 0, 16'd0, 16'd0, 16'd0, 0, IDLE);
        step("c_grant0",  1, 1, 1, 16'd1, 16'd2, 16'd0, 0, STA0);
        step("c_run0",    1, 1, 1, 16'd1, 16'd2, 16'd0, 0, RUN0);
        step("c_done0",   1, 1, 1, 16'd1, 16'd2, 16'd1, 0, DN0);
        step("c_rel0",    1, 1, 1, 16'd1, 16'd2, 16'd0, 0, HOLD0);
        step("c_idle",    1, 0, 1, 16'd1, 16'd2, 16'd0, 0, IDLE);
        step("c_grant1",  1, 0, 1, 16'd1, 16'd2, 16'd0, 0, STA1);
        step("c_run1",    1, 0, 1, 16'd1, 16'd2, 16'd0, 0, RUN1);
        step("c_done1",   1, 0, 1, 16'd1, 16'd2, 16'd2, 0, DN1);
        step("c_rel1",    1, 0, 1, 16'd1, 16'd2, 16'd0, 0, HOLD1);
        step("c_idle1",   1, 0, 0, 16'd1, 16'd2, 16'd0, 0, IDLE);
        step("c_tie0",    1, 1, 1, 16'd9, 16'd5, 16'd0, 0, STA0);
        step("c_tierun",  1, 0, 1, 16'd9, 16'd5, 16'd0, 0, RUN0);
        step("c_abort0",  1, 0, 1, 16'd9, 16'd5, 16'd0, 0, HOLD0);
        step("c_fin0",    1, 0, 1, 16'd9, 16'd5, 16'd0, 0, HOLD0);
        step("c_pend",    1, 0, 1, 16'd9, 16'd5, 16'd0, 0, IDLE);

        // Abort of requester 1 at TMR_TIME=2 < DUR1=5; DUR1 changes after grant
        step("a_grant1",  1, 0, 1, 16'd9, 16'd5, 16'd0, 0, STA1);
        step("a_run1",    1, 0, 1, 16'd9, 16'd0, 16'd0, 0, RUN1);
        step("a_t2",      1, 0, 1, 16'd9, 16'd0, 16'd2, 0, RUN1);
        step("a_abort",   1, 0, 0, 16'd9, 16'd0, 16'd2, 0, HOLD1);
        step("a_fin",     1, 0, 0, 16'd9, 16'd0, 16'd0, 0, HOLD1);
        step("a_idle",    1, 0, 0, 16'd9, 16'd0, 16'd0, 0, IDLE);

        // Zero duration, then overflow
        step("z_grant",   1, 1, 0, 16'd0, 16'd0, 16'd0, 0, STA0);
        step("z_run",     1, 1, 0, 16'd0, 16'd0, 16'd0, 0, RUN0);
        step("z_done",    1, 1, 0, 16'd0, 16'd0, 16'd0, 0, DN0);
        step("z_rel",     1, 1, 0, 16'd0, 16'd0, 16'd0, 0, HOLD0);
        step("z_idle",    1, 0, 0, 16'd0, 16'd0, 16'd0, 0, IDLE);
        step("o_grant",   1, 1, 0, 16'hFFFF, 16'd0, 16'd0, 0, STA0);
        step("o_run",     1, 1, 0, 16'hFFFF, 16'd0, 16'd0, 0, RUN0);
        step("o_t5",      1, 1, 0, 16'hFFFF, 16'd0, 16'd5, 0, RUN0);
        step("o_err",     1, 1, 0, 16'hFFFF, 16'd0, 16'h0010, 1, ERR0);
        step("o_rel",     1, 1, 0, 16'hFFFF, 16'd0, 16'd0, 0, HOLD0);
        step("o_idle",    1, 0, 0, 16'hFFFF, 16'd0, 16'd0, 0, IDLE);

        // Reset while requester 1 owns the timer
        step("r_grant1",  1, 0, 1, 16'd0, 16'd9, 16'd0, 0, STA1);
        step("r_run1",    1, 0, 1, 16'd0, 16'd9, 16'd0, 0, RUN1);
        step("r_t1",      1, 0, 1, 16'd0, 16'd9, 16'd1, 0, RUN1);
        step("r_reset",   0, 0, 1, 16'd0, 16'd9, 16'd9, 0, IDLE);
        step("r_after",   1, 0, 0, 16'd0, 16'd9, 16'd0, 0, IDLE);

        @(negedge MCLK);
        #1;
        check("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 SHALL have parameter: none; the block is fixed at two requesters and a 16-bit seconds timer.
REQ-002 SHALL have port: MCLK  in  1  system clock, rising edge.
REQ-003 SHALL have port: nRESET  in  1  reset, synchronous, active-low, sampled on the MCLK rising edge.
REQ-004 SHALL have ports: REQ0 / REQ1  in  1 each  level request; held high until DONE, or dropped to abort.
REQ-005 SHALL have ports: DUR0 / DUR1  in  16 each  requested duration in seconds, sampled only at grant.
REQ-006 SHALL have ports: GNT0 / GNT1  out  1 each  timer owned by requester 0 / 1.
REQ-007 SHALL have ports: DONE0 / DONE1  out  1 each  one-cycle pulse when the duration has elapsed.
REQ-008 SHALL have port: ERR  out  1  one-cycle pulse, timer overflow during the owner's run.
REQ-009 SHALL have port: BUSY  out  1  high whenever state is not IDLE.
REQ-010 SHALL have ports: TMR_nSTART  out  1  active-low start strobe to the seconds counter.
REQ-011 SHALL have port: TMR_nRESET  out  1  active-low clear to the seconds counter.
REQ-012 SHALL have ports: TMR_TIME  in  16  elapsed seconds; TMR_OVFL  in  1  counter saturated.

Function
REQ-013 SHALL implement states IDLE, START, RUN, FINISH and RELEASE; all outputs SHALL be registered.
REQ-014 In IDLE with any REQ high, SHALL grant at the next edge, latch the winner's DUR into dur_q, and enter START.
REQ-015 SHALL arbitrate round-robin: with both requests high, grant the requester not served last; last_q SHALL reset to 1, so requester 0 wins first.
REQ-016 With a single request high, SHALL grant that requester regardless of last_q.
REQ-017 In START (exactly 1 cycle): TMR_nSTART=0, TMR_nRESET=1, GNTx=1; then enter RUN.
REQ-018 In RUN: TMR_nSTART=1, TMR_nRESET=1; the exit conditions below SHALL be evaluated in priority order.
REQ-019 Exit priority 1: if REQx of the owner is low, SHALL abort to FINISH with no DONE and no ERR.
REQ-020 Exit priority 2: if TMR_OVFL=1, SHALL enter FINISH and pulse ERR and DONEx.
REQ-021 Exit priority 3: if TMR_TIME >= dur_q (16-bit unsigned compare), SHALL enter FINISH and pulse DONEx.
REQ-022 DONEx and ERR SHALL be high only in the first FINISH cycle.
REQ-023 DUR=0 SHALL produce DONE in the first RUN-exit evaluation, since TMR_TIME reads 0.
REQ-024 In FINISH (1 cycle): TMR_nRESET=0; update last_q to the owner; enter RELEASE.
REQ-025 In RELEASE: TMR_nRESET=0, GNTx held; when REQx is low, drop GNTx and return to IDLE.
REQ-026 A new grant SHALL NOT be issued until at least one IDLE cycle has elapsed.
REQ-027 In IDLE: TMR_nRESET=0, TMR_nSTART=1, both GNT low.
REQ-028 GNT0 and GNT1 SHALL never be high together.
REQ-029 A non-owner request during a run SHALL be held pending and served after RELEASE, not dropped.
REQ-030 DUR changes after grant SHALL have no effect on the current run.

Reset
REQ-031 While nRESET=0 at a clock edge, SHALL force state=IDLE, GNT0=GNT1=0, DONE0=DONE1=0, ERR=0, BUSY=0, TMR_nSTART=1, TMR_nRESET=0, dur_q=0, last_q=1.
REQ-032 Reset mid-RUN SHALL drop the grant in the same edge and leave the counter held cleared through TMR_nRESET=0.
REQ-033 Reset SHALL have no asynchronous effect.

Verification
REQ-034 Single request: REQ0=1, DUR0=3 -> GNT0 one cycle later, TMR_nSTART low 1 cycle, DONE0 pulse when TMR_TIME=3, then TMR_nRESET=0.
REQ-035 Contention: REQ0 and REQ1 rise together after reset -> requester 0 is served first; requester 1 is granted after REQ0 drops plus one IDLE cycle; the next tie goes to requester 0.
REQ-036 Abort: REQ1 drops while TMR_TIME=2 < DUR1=5 -> FINISH with no DONE1 and no ERR, GNT1 low, state returns to IDLE.
REQ-037 Zero duration and overflow: DUR0=0 -> DONE0 right after START. Then DUR0=16'hFFFF with TMR_OVFL forced to 1 -> ERR and DONE0 pulse together.
REQ-038 Reset mid-run: nRESET low while GNT1=1 -> next edge GNT1=0, BUSY=0, TMR_nRESET=0, no DONE pulse.
